// File: rtl/apb_pkg.sv
// Shared APB definitions: state encoding, default bus widths and timer sizing.
package apb_pkg;

    localparam int APB_DATA_W  = 8;
    localparam int APB_ADDR_W  = 2;
    localparam int APB_TIMEOUT = 16;

    localparam logic [1:0] APB_IDLE   = 2'b00;
    localparam logic [1:0] APB_SETUP  = 2'b01;
    localparam logic [1:0] APB_ACCESS = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = APB_IDLE,
        ST_SETUP  = APB_SETUP,
        ST_ACCESS = APB_ACCESS
    } apb_state_e;

    // Counter width able to hold 0..limit, never narrower than one bit.
    function automatic int timer_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response port plus APB bus of the APB initiator, bundled as one interface.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int DATA_W = APB_DATA_W,
    parameter int ADDR_W = APB_ADDR_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; flags the cycle in which a still-waiting
// transfer would reach LIMIT wait states. LIMIT=0 never expires.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int LIMIT = APB_TIMEOUT
) (
    input  logic clk,
    input  logic presetn,
    input  logic clear,
    input  logic enable,
    input  logic done,
    output logic expired
);

    localparam int            CW   = timer_width(LIMIT);
    localparam logic [CW-1:0] SAT  = CW'(LIMIT);
    localparam logic [CW-1:0] LAST = (LIMIT == 0) ? '0 : CW'(LIMIT - 1);

    logic [CW-1:0] count;

    // Count waiting cycles, restart on clear, hold once LIMIT is reached.
    always_ff @(posedge clk or negedge presetn) begin
        if (!presetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !done && (count != SAT)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (LIMIT != 0) && enable && !done && (count == LAST);

endmodule

// File: rtl/apb_master.sv
// APB initiator: turns one accepted command into one SETUP/ACCESS transfer,
// waits on pready with a timeout and returns a single-cycle response.
module apb_master
    import apb_pkg::*;
#(
    parameter int DATA_W  = APB_DATA_W,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic pclk,
    input  logic presetn,
    apb_master_if.master bus
);

    apb_state_e state, state_nxt;

    logic              accept;
    logic              xfer_ok;
    logic              xfer_abort;
    logic              tmo;
    logic              cmd_ready_c;
    logic              psel_c;
    logic              penable_c;

    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    apb_wait_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk     (pclk),
        .presetn (presetn),
        .clear   (accept),
        .enable  (state == ST_ACCESS),
        .done    (bus.pready),
        .expired (tmo)
    );

    // State register; reset kills any transfer in flight.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and bus strobes; pready only matters in ACCESS.
    always_comb begin
        state_nxt   = state;
        cmd_ready_c = 1'b0;
        psel_c      = 1'b0;
        penable_c   = 1'b0;
        accept      = 1'b0;
        xfer_ok     = 1'b0;
        xfer_abort  = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready_c = presetn;
                if (bus.cmd_valid && presetn) begin
                    accept    = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel_c    = 1'b1;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel_c    = 1'b1;
                penable_c = 1'b1;
                if (bus.pready) begin
                    xfer_ok   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tmo) begin
                    xfer_abort = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture the command on accept and hold it for the whole transfer and beyond.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else if (accept) begin
            paddr_q  <= bus.cmd_addr;
            pwrite_q <= bus.cmd_write;
            pwdata_q <= bus.cmd_wdata;
        end
    end

    // One-cycle response after completion or abort; data only for successful reads.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= xfer_ok || xfer_abort;
            rsp_err_q   <= xfer_abort;
            rsp_rdata_q <= (xfer_ok && !pwrite_q) ? bus.prdata : '0;
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.psel      = psel_c;
    assign bus.penable   = penable_c;
    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a transaction-level model predicts, per cycle, the bus
// strobes, cmd_ready and responses; a scripted slave drives pready/prdata.
module tb_apb_master;
    import apb_pkg::*;

    localparam int DW  = 8;
    localparam int AW  = 2;
    localparam int TMO = 16;

    typedef struct {
        bit            err;
        logic [DW-1:0] data;
    } rsp_t;

    logic pclk    = 1'b0;
    logic presetn = 1'b1;

    apb_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    apb_master #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit model_on = 1'b0;
    int busy_until = 0;

    bit            exp_busy[int];
    bit            exp_psel[int];
    bit            exp_pen[int];
    rsp_t          exp_rsp[int];
    logic [AW-1:0] exp_addr;
    logic          exp_wr;
    logic [DW-1:0] exp_wdata;

    bit            plan_rdy[int];
    logic [DW-1:0] plan_data[int];
    logic [DW-1:0] mem[4];
    logic [DW-1:0] mem_save[4];

    int n, n1, n2;

    // Cycle index: cycle k runs from rising edge k to rising edge k+1.
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic waitCycle(input int target);
        do @(negedge pclk); while (cyc < target);
    endtask

    task automatic clearModel();
        exp_busy.delete();
        exp_psel.delete();
        exp_pen.delete();
        exp_rsp.delete();
        plan_rdy.delete();
        plan_data.delete();
        busy_until = 0;
    endtask

    // Drive one command; accepted in the first cycle the model says the master is idle.
    // waits = number of pready=0 ACCESS cycles before the slave answers.
    task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input int waits, input bit setup_rdy, output int acc);
        int   acc_cycles, rsp_cyc;
        bit   ok;
        rsp_t r;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = data;
        while (cyc < busy_until) begin
            @(posedge pclk); #1;
        end
        acc        = cyc;
        ok         = (waits < TMO);
        acc_cycles = ok ? waits + 1 : TMO;
        rsp_cyc    = acc + 2 + acc_cycles;
        for (int k = acc + 1; k < rsp_cyc; k++) begin
            exp_busy[k] = 1'b1;
            exp_psel[k] = 1'b1;
            if (k >= acc + 2) begin
                exp_pen[k]  = 1'b1;
                plan_rdy[k] = 1'b0;
            end
        end
        plan_rdy[acc + 1] = setup_rdy ? 1'b1 : 1'($urandom % 2);
        exp_addr  = addr;
        exp_wr    = wr;
        exp_wdata = data;
        r.err  = !ok;
        r.data = (ok && !wr) ? mem[addr] : '0;
        if (ok) begin
            plan_rdy[rsp_cyc - 1]  = 1'b1;
            plan_data[rsp_cyc - 1] = wr ? DW'($urandom) : mem[addr];
            if (wr) mem[addr] = data;
        end
        exp_rsp[rsp_cyc] = r;
        busy_until = rsp_cyc;
        @(posedge pclk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_wdata = DW'($urandom);
    endtask

    // Scripted slave: follows the plan where one exists, otherwise drives noise.
    initial begin
        bus.pready = 1'b0;
        bus.prdata = '0;
        forever begin
            @(posedge pclk); #1;
            if (plan_rdy.exists(cyc)) begin
                bus.pready = plan_rdy[cyc];
                bus.prdata = plan_data.exists(cyc) ? plan_data[cyc] : DW'($urandom);
            end else begin
                bus.pready = 1'($urandom % 2);
                bus.prdata = DW'($urandom);
            end
        end
    end

    // Compare every cycle against the model while it is tracking the DUT.
    always @(negedge pclk) begin
        if (model_on && presetn) begin
            checkOutput("m_cmd_ready", bus.cmd_ready, !exp_busy.exists(cyc));
            checkOutput("m_psel", bus.psel, exp_psel.exists(cyc));
            checkOutput("m_penable", bus.penable, exp_pen.exists(cyc));
            checkOutput("m_rsp_valid", bus.rsp_valid, exp_rsp.exists(cyc));
            if (exp_psel.exists(cyc)) begin
                checkOutput("m_paddr", bus.paddr, exp_addr);
                checkOutput("m_pwrite", bus.pwrite, exp_wr);
                checkOutput("m_pwdata", bus.pwdata, exp_wdata);
            end
            if (exp_rsp.exists(cyc)) begin
                checkOutput("m_rsp_err", bus.rsp_err, exp_rsp[cyc].err);
                checkOutput("m_rsp_rdata", bus.rsp_rdata, exp_rsp[cyc].data);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios with hand-computed expectations, then random traffic.
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        mem[0] = 8'h3C; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;
        n1 = -1;

        #1 presetn = 1'b0;
        #2;
        checkOutput("rst_psel", bus.psel, 0);
        checkOutput("rst_penable", bus.penable, 0);
        checkOutput("rst_cmd_ready", bus.cmd_ready, 0);
        checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
        checkOutput("rst_rsp_err", bus.rsp_err, 0);
        checkOutput("rst_rsp_rdata", bus.rsp_rdata, 0);
        checkOutput("rst_paddr", bus.paddr, 0);
        checkOutput("rst_pwrite", bus.pwrite, 0);
        checkOutput("rst_pwdata", bus.pwdata, 0);
        #9 presetn = 1'b1;
        #1 checkOutput("rel_cmd_ready", bus.cmd_ready, 1);
        model_on = 1'b1;
        @(posedge pclk); #1;

        // Zero-wait write to address 2.
        applyStimulus(1'b1, 2'd2, 8'hA5, 0, 1'b0, n);
        waitCycle(n + 1);
        checkOutput("wr_setup_psel", bus.psel, 1);
        checkOutput("wr_setup_pen", bus.penable, 0);
        waitCycle(n + 2);
        checkOutput("wr_acc_pen", bus.penable, 1);
        checkOutput("wr_acc_paddr", bus.paddr, 2);
        checkOutput("wr_acc_pwrite", bus.pwrite, 1);
        checkOutput("wr_acc_pwdata", bus.pwdata, 8'hA5);
        waitCycle(n + 3);
        checkOutput("wr_rsp_valid", bus.rsp_valid, 1);
        checkOutput("wr_rsp_err", bus.rsp_err, 0);
        checkOutput("wr_rsp_rdata", bus.rsp_rdata, 0);
        checkOutput("wr_rsp_psel", bus.psel, 0);
        @(posedge pclk); #1;

        // Read address 0 with three wait states.
        applyStimulus(1'b0, 2'd0, 8'h00, 3, 1'b0, n);
        for (int k = 2; k <= 5; k++) begin
            waitCycle(n + k);
            checkOutput("rd_wait_pen", bus.penable, 1);
        end
        waitCycle(n + 6);
        checkOutput("rd_end_pen", bus.penable, 0);
        checkOutput("rd_rsp_valid", bus.rsp_valid, 1);
        checkOutput("rd_rsp_rdata", bus.rsp_rdata, 8'h3C);
        @(posedge pclk); #1;

        // Slave never answers: abort after 16 ACCESS cycles.
        applyStimulus(1'b0, 2'd1, 8'h00, 1000, 1'b0, n);
        waitCycle(n + 17);
        checkOutput("to_last_pen", bus.penable, 1);
        checkOutput("to_last_rsp", bus.rsp_valid, 0);
        waitCycle(n + 18);
        checkOutput("to_psel", bus.psel, 0);
        checkOutput("to_penable", bus.penable, 0);
        checkOutput("to_rsp_valid", bus.rsp_valid, 1);
        checkOutput("to_rsp_err", bus.rsp_err, 1);
        checkOutput("to_rsp_rdata", bus.rsp_rdata, 0);
        checkOutput("to_cmd_ready", bus.cmd_ready, 1);
        @(posedge pclk); #1;

        // Back-to-back write then read of address 0 with cmd_valid held.
        fork
            begin
                applyStimulus(1'b1, 2'd0, 8'h0D, 0, 1'b0, n1);
                applyStimulus(1'b0, 2'd0, 8'h5E, 0, 1'b0, n2);
            end
            begin
                wait (n1 >= 0);
                waitCycle(n1 + 3);
                checkOutput("b2b_rsp1", bus.rsp_valid, 1);
                checkOutput("b2b_ready", bus.cmd_ready, 1);
                checkOutput("b2b_gap_psel", bus.psel, 0);
                waitCycle(n1 + 4);
                checkOutput("b2b_setup2", bus.psel, 1);
                checkOutput("b2b_setup2_pen", bus.penable, 0);
                waitCycle(n1 + 6);
                checkOutput("b2b_rsp2", bus.rsp_valid, 1);
                checkOutput("b2b_rdata", bus.rsp_rdata, 8'h0D);
            end
        join
        @(posedge pclk); #1;

        // pready high only during SETUP, then two waits.
        applyStimulus(1'b1, 2'd3, 8'h77, 2, 1'b1, n);
        waitCycle(n + 2);
        checkOutput("sr_acc_pen", bus.penable, 1);
        checkOutput("sr_no_rsp", bus.rsp_valid, 0);
        waitCycle(n + 4);
        checkOutput("sr_paddr", bus.paddr, 3);
        checkOutput("sr_pwdata", bus.pwdata, 8'h77);
        waitCycle(n + 5);
        checkOutput("sr_rsp", bus.rsp_valid, 1);
        checkOutput("sr_rsp_err", bus.rsp_err, 0);
        @(posedge pclk); #1;

        // Reset pulse in the middle of a waiting write.
        mem_save = mem;
        applyStimulus(1'b1, 2'd1, 8'h5A, 6, 1'b0, n);
        waitCycle(n + 3);
        checkOutput("rm_psel", bus.psel, 1);
        checkOutput("rm_pen", bus.penable, 1);
        #2;
        model_on = 1'b0;
        presetn  = 1'b0;
        #1;
        checkOutput("rm_async_psel", bus.psel, 0);
        checkOutput("rm_async_pen", bus.penable, 0);
        checkOutput("rm_async_rsp", bus.rsp_valid, 0);
        checkOutput("rm_async_ready", bus.cmd_ready, 0);
        @(negedge pclk); #2;
        presetn = 1'b1;
        clearModel();
        mem = mem_save;
        #1 checkOutput("rm_rel_ready", bus.cmd_ready, 1);
        model_on = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            waitCycle(cyc + 1);
            checkOutput("rm_post_ready", bus.cmd_ready, 1);
            checkOutput("rm_post_rsp", bus.rsp_valid, 0);
        end
        @(posedge pclk); #1;

        // Random traffic, wait states spanning both sides of the timeout.
        for (int t = 0; t < 150; t++) begin
            int r, w, g;
            r = $urandom_range(0, 9);
            if (r < 6)       w = $urandom_range(0, 3);
            else if (r < 8)  w = $urandom_range(4, 14);
            else if (r == 8) w = $urandom_range(TMO - 1, TMO);
            else             w = $urandom_range(TMO + 1, TMO + 9);
            applyStimulus(1'($urandom), AW'($urandom), DW'($urandom), w, 1'b0, n);
            g = $urandom_range(0, 3);
            repeat (g) begin
                @(posedge pclk); #1;
            end
        end
        while (cyc <= busy_until + 2) begin
            @(posedge pclk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator that drives the UART register slave (baud, TX data, status registers) from a simple command/response port.
- Callers are a host bridge, a test sequencer or a boot ROM engine.
- Converts one accepted command into one APB SETUP/ACCESS transfer, waits on pready, and returns read data or an error response.
- A wait-state timeout prevents a hung slave from locking the command port.

Parameters:
- DATA_W, 8: APB data width (pwdata, prdata, cmd_wdata, rsp_rdata).
- ADDR_W, 2: APB address width; 4 registers by default.
- TIMEOUT, 16: maximum ACCESS cycles with pready=0 before abort. 0 disables the timeout.

Ports:
- pclk  in  1  APB clock; all logic on the rising edge.
- presetn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  register address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  timeout abort; qualified by rsp_valid.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pready  in  1  slave ready.
- prdata  in  DATA_W  slave read data.

Behaviour:
- State machine has three states: IDLE, SETUP, ACCESS. Reset state is IDLE.
- Reset (presetn=0, async):
  - State goes to IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err are all 0.
  - cmd_ready is 0 while presetn=0.
  - Wait counter is 0.
- cmd_ready = (state==IDLE) & presetn. It is combinational; no skid buffer.
- IDLE:
  - On cmd_valid&cmd_ready in cycle N, latch cmd_addr, cmd_write, and cmd_wdata into paddr, pwrite, pwdata.
  - psel=1 from N+1; go to SETUP.
- SETUP (one cycle only):
  - psel=1, penable=0.
  - pready is ignored here; the slave may drive it low.
  - Next state is ACCESS with penable=1.
- ACCESS:
  - psel=1, penable=1. paddr, pwrite, pwdata are held stable.
  - pready=0: stay in ACCESS and increment the wait counter, saturating at TIMEOUT.
  - pready=1: sample prdata if read. Go to IDLE with psel=0 and penable=0 next cycle.
  - In that same next cycle: rsp_valid=1, rsp_err=0, rsp_rdata = sampled prdata (read) or 0 (write).
  - Timeout: TIMEOUT!=0 and the counter reaches TIMEOUT with pready still 0. Abort to IDLE and deassert psel/penable. Pulse rsp_valid with rsp_err=1, rsp_rdata=0.
  - pready=1 on the same cycle the counter reaches TIMEOUT counts as success; pready wins.
- Wait counter:
  - Cleared on entry to SETUP.
  - Width is clog2(TIMEOUT+1), minimum 1.
- Latency:
  - Zero-wait transfer: accept at N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3.
  - Each wait state adds 1 cycle.
  - A new command may be accepted in the rsp_valid cycle, giving a throughput of 1 transfer per 3 cycles.
- rsp_valid is a pulse only. There is no response backpressure; the consumer must sample it.
- pwdata is left holding its last value after a transfer; paddr/pwrite are likewise unchanged until the next accept.
- Reset mid-transfer:
  - Bus deasserts immediately (async).
  - No response is generated for the killed command.
  - After reset release, cmd_ready=1 on the first clock.

Decomposition:
- Shared package apb_pkg:
  - Constants APB_IDLE=2'b00, APB_SETUP=2'b01, APB_ACCESS=2'b10 for the state encoding.
  - Default DATA_W/ADDR_W constants, shared with the UART register slave.
- One natural sub-module: apb_wait_timer.
  - Inputs: clear, enable, done.
  - Output: saturating counter with a timeout flag.
  - Reused for other bus masters.
- The FSM and datapath stay in apb_master.

Test Plan:
- Write addr=2 data=8'hA5, pready=1 in ACCESS: psel at N+1, penable at N+2 with paddr=2, pwrite=1, pwdata=A5. rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read addr=0, slave holds pready=0 for 3 ACCESS cycles then returns prdata=8'h3C with pready=1: penable high for 4 cycles. rsp_valid 1 cycle later with rsp_rdata=3C.
- Read with pready stuck 0, TIMEOUT=16: ACCESS lasts 16 cycles, then psel/penable drop. rsp_valid with rsp_err=1, rsp_rdata=0; cmd_ready returns to 1.
- Back-to-back: write addr=0 0x0D, then read addr=0, cmd_valid held high. Second accept occurs in the first rsp_valid cycle; read returns 0x0D from the register slave. No overlap of psel between transfers beyond one IDLE cycle.
- presetn pulsed low during ACCESS of a write: psel/penable/rsp_valid go 0 asynchronously. No response pulse after release; cmd_ready=1 on the first clock after release.
- pready=1 asserted during SETUP only, then 0: SETUP ignores it. ACCESS waits for the next pready=1; paddr/pwdata stay stable throughout.
